pipe_scoreboard: RTL and testbench
==================================

// Module: pipe_scoreboard
// PURPOSE
//  Issue-stage hazard scoreboard for the next-generation pipelined MIPS core, where execution units have variable latency.
//  Tracks every in-flight register write in a writeback slot line.
//  Stalls issue on RAW, WAW and writeback-port structural hazards.
//  Emits the writeback strobe. Sits between CPU_Controller decode outputs and the CPU_Data issue register.
// PARAMETERS
//  NREGS   32  architectural registers; register 0 is hard-wired zero
//  AW      5   register index width, $clog2(NREGS)
//  MAXLAT  8   maximum unit latency in cycles, >=2
//  LW      4   latency/count width, $clog2(MAXLAT+1)
// PORTS
//  Clk           in   1   clock, rising edge
//  Rst           in   1   asynchronous, active-low reset
//  issue_valid   in   1   decoded instruction presented for issue
//  issue_rs      in   AW  source register 1 (always read)
//  issue_rt      in   AW  source register 2
//  issue_uses_rt in   1   rt is a real source (0 for immediate forms)
//  issue_wr      in   1   instruction writes issue_rd
//  issue_rd      in   AW  destination register
//  issue_lat     in   LW  result latency in cycles
//  flush         in   1   kill the presented instruction (branch taken)
//  issue_fire    out  1   instruction accepted this cycle (combinational)
//  stall         out  1   instruction held by a hazard (combinational)
//  wb_valid      out  1   writeback occurs this cycle (registered)
//  wb_rd         out  AW  writeback destination (registered)
//  inflight      out  LW  number of valid slots (registered)
// BEHAVIOUR
//  - Slot line slot[1..MAXLAT], each {valid, rd}. Every edge: slot[k] <= slot[k+1]; slot[MAXLAT] <= empty.
//  - Fire with effective latency L writes slot[L] on the same edge. It overrides the shifted value.
//  - The write occurs only when issue_wr=1 and issue_rd!=0. Fire with no write occupies nothing.
//  - Effective L: issue_lat==0 -> 1; issue_lat>MAXLAT -> MAXLAT; else issue_lat.
//  - wb_valid=slot[1].valid and wb_rd=slot[1].rd. Instruction fired at cycle t with latency L -> wb_valid high at cycle t+L.
//  - busy(r) = r!=0 and some slot[k], k>=2, is valid with rd==r. slot[1] is not busy; the datapath forwards from WB.
//  - RAW hazard: busy(rs), or issue_uses_rt and busy(rt).
//  - WAW hazard: issue_wr and busy(rd). A same-register write retiring in slot[1] is not a hazard.
//  - STRUCT hazard: issue_wr, rd!=0, and slot[L+1] valid (L<MAXLAT). This prevents two writebacks in one cycle.
//  - hazard = RAW | WAW | STRUCT.
//  - issue_fire = issue_valid & ~flush & ~hazard; stall = issue_valid & ~flush & hazard.
//  - flush has priority over hazards: no fire, no stall, no slot written. In-flight slots are unaffected by flush.
//  - inflight = popcount of valid slots after the edge. It never exceeds MAXLAT.
//  - Reset (Rst=0, any time, including mid-operation): all slots invalid.
//    wb_valid=0, wb_rd=0, inflight=0, stats counters=0. Combinational outputs follow from the inputs.
// CONFIGURATION
//  SCOREBOARD_STATS_EN defined:
//  - Adds outputs stat_raw, stat_waw, stat_struct, 16 bits each.
//  - Each counter is saturating at 16'hFFFF and increments on every stall cycle whose hazard includes that cause.
//  - One stall cycle can bump several counters.
//  - Counters are cleared only by reset.
//  SCOREBOARD_STATS_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.
// STRUCTURE
//  - cpu_pipe_pkg holds:
//    - typedef wb_slot_t {valid, rd};
//    - hazard-cause enum {HZ_RAW, HZ_WAW, HZ_STRUCT};
//    - latency clamp function;
//    - default MAXLAT constant.
//  - Sub-module wb_slot_line: the shifting slot array with insert port, exposing slot vector and inflight.
//  - The hazard logic stays in pipe_scoreboard.
// TESTING
//  - Reset: hold Rst=0 for 3 cycles, then release. Expect wb_valid=0 and inflight=0; issue rs=1 -> fire=1 immediately.
//  - RAW: fire rd=5, lat=4 at t0. At t0+1..t0+3, rs=5 -> stall=1. At t0+4, wb_valid=1, wb_rd=5, and rs=5 fires.
//  - Structural hazard:
//    - fire rd=3, lat=3 at t0;
//    - at t0+1, rd=4 lat=2 -> stall (both would retire at t0+3);
//    - at t0+2, rd=4 lat=2 fires, wb at t0+4.
//  - Register 0 and clamping:
//    - rd=0, lat=5 fires with inflight unchanged and no wb;
//    - lat=0 -> wb next cycle;
//    - lat=15 -> wb after MAXLAT=8 cycles.
//  - Flush and WAW: rd=7 in flight, new write rd=7 with flush=1 -> fire=0, stall=0, and the in-flight wb still occurs.
//  - Mid-op reset: assert Rst=0 with 4 slots valid -> wb_valid=0 and inflight=0 asynchronously. With stats on, counters read 0.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared types for the pipelined core's issue scoreboard: writeback slot record,
// hazard-cause encoding and the latency clamp.
package cpu_pipe_pkg;

    localparam int MAXLAT_DEF = 8;
    localparam int AW_DEF     = 5;

    typedef struct packed {
        logic              valid;
        logic [AW_DEF-1:0] rd;
    } wb_slot_t;

    typedef enum logic [1:0] {
        HZ_RAW    = 2'd0,
        HZ_WAW    = 2'd1,
        HZ_STRUCT = 2'd2
    } hz_cause_e;

    // Zero-latency requests still need one cycle; anything beyond the line saturates.
    function automatic int clamp_lat(input int lat, input int maxlat);
        if (lat == 0)
            return 1;
        else if (lat > maxlat)
            return maxlat;
        else
            return lat;
    endfunction

endpackage

// File: rtl/wb_slot_line.sv
// Writeback slot line: slot[k] moves to slot[k-1] each cycle, slot[1] is retiring.
// An insert lands directly in slot[ins_lat], overriding the shifted entry.
module wb_slot_line
    import cpu_pipe_pkg::*;
#(
    parameter int MAXLAT = MAXLAT_DEF,
    parameter int LW     = 4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    ins_en,
    input  logic [LW-1:0]           ins_lat,
    input  logic [AW_DEF-1:0]       ins_rd,
    output wb_slot_t [MAXLAT:1]     slots,
    output logic [LW-1:0]           inflight
);

    wb_slot_t [MAXLAT:1] slot_q, slot_d;
    logic [LW-1:0]       inflight_q, inflight_d;

    always_comb begin
        slot_d     = '0;
        inflight_d = '0;
        for (int k = 1; k < MAXLAT; k++)
            slot_d[k] = slot_q[k+1];
        for (int k = 1; k <= MAXLAT; k++) begin
            if (ins_en && ins_lat == LW'(k)) begin
                slot_d[k].valid = 1'b1;
                slot_d[k].rd    = ins_rd;
            end
        end
        for (int k = 1; k <= MAXLAT; k++)
            inflight_d = inflight_d + LW'(slot_d[k].valid);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            slot_q     <= '0;
            inflight_q <= '0;
        end else begin
            slot_q     <= slot_d;
            inflight_q <= inflight_d;
        end
    end

    assign slots    = slot_q;
    assign inflight = inflight_q;

endmodule

// File: rtl/pipe_scoreboard.sv
// Issue-stage hazard scoreboard: stalls on RAW, WAW and writeback-port collisions.
// Defining SCOREBOARD_STATS_EN adds saturating per-cause stall counters.
module pipe_scoreboard
    import cpu_pipe_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int MAXLAT = MAXLAT_DEF,
    parameter int LW     = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rs,
    input  logic [AW-1:0] issue_rt,
    input  logic          issue_uses_rt,
    input  logic          issue_wr,
    input  logic [AW-1:0] issue_rd,
    input  logic [LW-1:0] issue_lat,
    input  logic          flush,
    output logic          issue_fire,
    output logic          stall,
    output logic          wb_valid,
    output logic [AW-1:0] wb_rd,
    output logic [LW-1:0] inflight
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [15:0]   stat_raw,
    output logic [15:0]   stat_waw,
    output logic [15:0]   stat_struct
`endif
);

    wb_slot_t [MAXLAT:1] slots;
    logic [NREGS-1:0]    busy_vec;
    logic [LW-1:0]       lat_eff;
    logic                wr_real;
    logic                struct_hit;
    logic [2:0]          hz_cause;
    logic                hazard;
    logic                ins_en;

    assign lat_eff = LW'(clamp_lat(int'(issue_lat), MAXLAT));
    assign wr_real = issue_wr && (issue_rd != '0);

    // slot[1] is excluded: its value reaches the datapath through WB forwarding.
    always_comb begin
        busy_vec   = '0;
        struct_hit = 1'b0;
        for (int r = 1; r < NREGS; r++)
            for (int k = 2; k <= MAXLAT; k++)
                if (slots[k].valid && slots[k].rd == AW'(r))
                    busy_vec[r] = 1'b1;
        for (int k = 2; k <= MAXLAT; k++)
            if (slots[k].valid && lat_eff == LW'(k - 1))
                struct_hit = 1'b1;
    end

    always_comb begin
        hz_cause            = '0;
        hz_cause[HZ_RAW]    = busy_vec[issue_rs] | (issue_uses_rt & busy_vec[issue_rt]);
        hz_cause[HZ_WAW]    = issue_wr & busy_vec[issue_rd];
        hz_cause[HZ_STRUCT] = wr_real & struct_hit;
    end

    assign hazard     = |hz_cause;
    assign issue_fire = issue_valid & ~flush & ~hazard;
    assign stall      = issue_valid & ~flush & hazard;
    assign ins_en     = issue_fire & wr_real;

    wb_slot_line #(
        .MAXLAT (MAXLAT),
        .LW     (LW)
    ) u_slot_line (
        .Clk      (Clk),
        .Rst      (Rst),
        .ins_en   (ins_en),
        .ins_lat  (lat_eff),
        .ins_rd   (issue_rd),
        .slots    (slots),
        .inflight (inflight)
    );

    assign wb_valid = slots[1].valid;
    assign wb_rd    = slots[1].rd;

`ifdef SCOREBOARD_STATS_EN
    logic [15:0] raw_cnt_q, waw_cnt_q, struct_cnt_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            raw_cnt_q    <= '0;
            waw_cnt_q    <= '0;
            struct_cnt_q <= '0;
        end else if (stall) begin
            if (hz_cause[HZ_RAW] && raw_cnt_q != 16'hFFFF)
                raw_cnt_q <= raw_cnt_q + 16'd1;
            if (hz_cause[HZ_WAW] && waw_cnt_q != 16'hFFFF)
                waw_cnt_q <= waw_cnt_q + 16'd1;
            if (hz_cause[HZ_STRUCT] && struct_cnt_q != 16'hFFFF)
                struct_cnt_q <= struct_cnt_q + 16'd1;
        end
    end

    assign stat_raw    = raw_cnt_q;
    assign stat_waw    = waw_cnt_q;
    assign stat_struct = struct_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: reset, RAW, structural, r0/clamping, flush/WAW, mid-op reset.
module tb_pipe_scoreboard;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       issue_valid, issue_uses_rt, issue_wr, flush;
    logic [4:0] issue_rs, issue_rt, issue_rd;
    logic [3:0] issue_lat;
    logic       issue_fire, stall, wb_valid;
    logic [4:0] wb_rd;
    logic [3:0] inflight;
`ifdef SCOREBOARD_STATS_EN
    logic [15:0] stat_raw, stat_waw, stat_struct;
`endif

    int ntests = 0;
    int nfail  = 0;

    always #5 Clk = ~Clk;

    pipe_scoreboard dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .issue_valid   (issue_valid),
        .issue_rs      (issue_rs),
        .issue_rt      (issue_rt),
        .issue_uses_rt (issue_uses_rt),
        .issue_wr      (issue_wr),
        .issue_rd      (issue_rd),
        .issue_lat     (issue_lat),
        .flush         (flush),
        .issue_fire    (issue_fire),
        .stall         (stall),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .inflight      (inflight)
`ifdef SCOREBOARD_STATS_EN
        ,
        .stat_raw      (stat_raw),
        .stat_waw      (stat_waw),
        .stat_struct   (stat_struct)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt, input logic wr, input logic [4:0] rd,
                         input logic [3:0] lat, input logic fl);
        issue_valid   = v;
        issue_rs      = rs;
        issue_rt      = rt;
        issue_uses_rt = urt;
        issue_wr      = wr;
        issue_rd      = rd;
        issue_lat     = lat;
        flush         = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
    endtask

    initial begin
        Rst = 1'b0;
        idle();

        // reset
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        Rst = 1'b1;
        drive(1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1, 1'b0);
        chk("rst_fire", 32'(issue_fire), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        tick();
        chk("nowr_inflight", 32'(inflight), 32'd0);

        // RAW
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 4'd4, 1'b0);
        chk("raw_t0_fire", 32'(issue_fire), 32'd1);
        tick();
        chk("raw_t1_inflight", 32'(inflight), 32'd1);
        drive(1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1, 1'b0);
        chk("raw_t1_stall", 32'(stall), 32'd1);
        chk("raw_t1_fire", 32'(issue_fire), 32'd0);
        tick();
        chk("raw_t2_stall", 32'(stall), 32'd1);
        tick();
        chk("raw_t3_stall", 32'(stall), 32'd1);
        chk("raw_t3_wb", 32'(wb_valid), 32'd0);
        tick();
        chk("raw_t4_wb", 32'(wb_valid), 32'd1);
        chk("raw_t4_wbrd", 32'(wb_rd), 32'd5);
        chk("raw_t4_fire", 32'(issue_fire), 32'd1);
        tick();
        idle();
        chk("raw_t5_wb", 32'(wb_valid), 32'd0);
        chk("raw_t5_inflight", 32'(inflight), 32'd0);

        // structural
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 4'd3, 1'b0);
        chk("st_t0_fire", 32'(issue_fire), 32'd1);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd4, 4'd2, 1'b0);
        chk("st_t1_stall", 32'(stall), 32'd1);
        chk("st_t1_fire", 32'(issue_fire), 32'd0);
        tick();
        chk("st_t2_fire", 32'(issue_fire), 32'd1);
        chk("st_t2_stall", 32'(stall), 32'd0);
        tick();
        idle();
        chk("st_t3_wb", 32'(wb_valid), 32'd1);
        chk("st_t3_wbrd", 32'(wb_rd), 32'd3);
        chk("st_t3_inflight", 32'(inflight), 32'd2);
        tick();
        chk("st_t4_wb", 32'(wb_valid), 32'd1);
        chk("st_t4_wbrd", 32'(wb_rd), 32'd4);
        chk("st_t4_inflight", 32'(inflight), 32'd1);
        tick();
        chk("st_t5_wb", 32'(wb_valid), 32'd0);
        chk("st_t5_inflight", 32'(inflight), 32'd0);

        // register 0 and latency clamping
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 4'd5, 1'b0);
        chk("r0_fire", 32'(issue_fire), 32'd1);
        tick();
        chk("r0_inflight", 32'(inflight), 32'd0);
        chk("r0_wb", 32'(wb_valid), 32'd0);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd6, 4'd0, 1'b0);
        chk("lat0_fire", 32'(issue_fire), 32'd1);
        tick();
        idle();
        chk("lat0_wb", 32'(wb_valid), 32'd1);
        chk("lat0_wbrd", 32'(wb_rd), 32'd6);
        chk("lat0_inflight", 32'(inflight), 32'd1);
        tick();
        chk("lat0_drain", 32'(inflight), 32'd0);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd10, 4'd15, 1'b0);
        chk("lat15_fire", 32'(issue_fire), 32'd1);
        tick();
        idle();
        chk("lat15_t1_inflight", 32'(inflight), 32'd1);
        repeat (6) tick();
        chk("lat15_t7_wb", 32'(wb_valid), 32'd0);
        tick();
        chk("lat15_t8_wb", 32'(wb_valid), 32'd1);
        chk("lat15_t8_wbrd", 32'(wb_rd), 32'd10);
        tick();
        chk("lat15_t9_inflight", 32'(inflight), 32'd0);

        // flush and WAW
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 4'd4, 1'b0);
        chk("fl_t0_fire", 32'(issue_fire), 32'd1);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 4'd2, 1'b1);
        chk("fl_fire", 32'(issue_fire), 32'd0);
        chk("fl_stall", 32'(stall), 32'd0);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 4'd2, 1'b0);
        chk("waw_stall", 32'(stall), 32'd1);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 4'd2, 1'b1);
        tick();
        chk("fl_t2_inflight", 32'(inflight), 32'd1);
        tick();
        tick();
        chk("fl_t4_wb", 32'(wb_valid), 32'd1);
        chk("fl_t4_wbrd", 32'(wb_rd), 32'd7);
        chk("fl_t4_inflight", 32'(inflight), 32'd1);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 4'd2, 1'b0);
        chk("waw_retiring_fire", 32'(issue_fire), 32'd1);
        tick();
        idle();
        chk("waw_t5_wb", 32'(wb_valid), 32'd0);
        chk("waw_t5_inflight", 32'(inflight), 32'd1);
        tick();
        chk("waw_t6_wb", 32'(wb_valid), 32'd1);
        chk("waw_t6_wbrd", 32'(wb_rd), 32'd7);
        tick();
        chk("waw_t7_inflight", 32'(inflight), 32'd0);

        // rt only counts when used
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd9, 4'd3, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd9, 1'b0, 1'b0, 5'd0, 4'd1, 1'b0);
        chk("rt_unused_fire", 32'(issue_fire), 32'd1);
        drive(1'b1, 5'd0, 5'd9, 1'b1, 1'b0, 5'd0, 4'd1, 1'b0);
        chk("rt_used_stall", 32'(stall), 32'd1);
        idle();
        tick();
        tick();
        chk("rt_t3_wbrd", 32'(wb_rd), 32'd9);
        tick();
        chk("rt_t4_inflight", 32'(inflight), 32'd0);

        // mid-operation reset
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd11, 4'd4, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd12, 4'd4, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd13, 4'd4, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd14, 4'd4, 1'b0);
        tick();
        idle();
        chk("mid_inflight", 32'(inflight), 32'd4);
        chk("mid_wb", 32'(wb_valid), 32'd1);
        chk("mid_wbrd", 32'(wb_rd), 32'd11);
        Rst = 1'b0;
        #1;
        chk("mid_rst_wb", 32'(wb_valid), 32'd0);
        chk("mid_rst_wbrd", 32'(wb_rd), 32'd0);
        chk("mid_rst_inflight", 32'(inflight), 32'd0);
`ifdef SCOREBOARD_STATS_EN
        chk("mid_rst_stat_raw", 32'(stat_raw), 32'd0);
        chk("mid_rst_stat_waw", 32'(stat_waw), 32'd0);
        chk("mid_rst_stat_struct", 32'(stat_struct), 32'd0);
`endif
        drive(1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1, 1'b0);
        chk("in_rst_fire", 32'(issue_fire), 32'd1);
        idle();
        tick();
        Rst = 1'b1;
        tick();
        chk("post_rst_inflight", 32'(inflight), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
